// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// The optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
package loader_pkg;

    localparam int HDR_W  = 16;
    localparam int LANE_W = 2;
    localparam int WORD_W = 32;

    // ST_WLAST covers the write-strobe cycle of the final word, so that the
    // completion state is entered only after that strobe.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WLAST = 3'd4,
        ST_CSUM  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } loader_state_e;

    // States in which the loader takes bytes from the stream.
    function automatic logic is_stream_state(loader_state_e s);
        return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory test write port of the loader.
// Handshake: a byte moves on a rising clk edge where rx_valid && rx_ready;
// the source holds rx_data stable while rx_valid is high and not yet accepted,
// and rx_ready is a registered output that never depends on rx_valid.
interface imem_loader_if;
    import loader_pkg::*;

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic [WORD_W-1:0] imem_test_addr;
    logic [WORD_W-1:0] imem_test_data;
    logic              imem_test_we;

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_test_addr, imem_test_data, imem_test_we
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_test_addr, imem_test_data, imem_test_we
    );

endinterface

// File: rtl/byte_packer.sv
// Collects little-endian stream bytes into 32-bit words; lane 3 completes a word.
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [LANE_W-1:0] lane,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    logic [23:0] low_q, low_d;

    // Capture lanes 0..2; lane 3 is taken straight from the input byte.
    always_comb begin
        low_d = low_q;
        if (en) begin
            case (lane)
                2'd0:    low_d[7:0]   = byte_in;
                2'd1:    low_d[15:8]  = byte_in;
                2'd2:    low_d[23:16] = byte_in;
                default: low_d        = low_q;
            endcase
        end
    end

    // Lane byte register; cleared by reset so no stale bytes survive an abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) low_q <= '0;
        else        low_q <= low_d;
    end

    assign word      = {byte_in, low_q};
    assign word_done = en && (lane == LANE_W'(3));

endmodule

// File: rtl/imem_loader.sv
// Loads instruction memory from a length-prefixed little-endian byte stream and
// holds the core in reset until a load completes.
// Optional feature macro: LOADER_CHECKSUM_EN (XOR checksum byte after the payload).
module imem_loader
    import loader_pkg::*;
#(
    parameter int MAX_WORDS = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          error,
    output loader_state_e state_dbg
);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e TAIL_STATE = ST_CSUM;
`else
    localparam loader_state_e TAIL_STATE = ST_DONE;
`endif

    loader_state_e     state_q, state_d;
    logic [7:0]        hdr_lo_q, hdr_lo_d;
    logic [HDR_W-1:0]  count_q, count_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [HDR_W-1:0]  idx_q, idx_d;
    logic              rx_ready_q, rx_ready_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              accept;
    logic              restart;
    logic [HDR_W-1:0]  hdr_count;
    logic [WORD_W-1:0] packed_word;
    logic              word_done;

    assign accept    = bus.rx_valid && rx_ready_q;
    assign hdr_count = {bus.rx_data, hdr_lo_q};

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .en        (accept && (state_q == ST_DATA)),
        .lane      (lane_q),
        .byte_in   (bus.rx_data),
        .word      (packed_word),
        .word_done (word_done)
    );

    // Next-state, counters and registered-output values derived from the next state.
    always_comb begin
        state_d  = state_q;
        hdr_lo_d = hdr_lo_q;
        count_d  = count_q;
        lane_d   = lane_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = 1'b0;
        restart  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            ST_IDLE: restart = start;
            ST_HDR0: begin
                if (accept) begin
                    hdr_lo_d = bus.rx_data;
                    state_d  = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (accept) begin
                    count_d = hdr_count;
                    if (hdr_count == '0)                        state_d = TAIL_STATE;
                    else if (hdr_count > HDR_W'(MAX_WORDS))     state_d = ST_ERR;
                    else                                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    lane_d = lane_q + LANE_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.rx_data;
`endif
                    if (word_done) begin
                        we_d   = 1'b1;
                        addr_d = {{(WORD_W-HDR_W){1'b0}}, idx_q};
                        data_d = packed_word;
                        idx_d  = idx_q + HDR_W'(1);
                        if ((idx_q + HDR_W'(1)) == count_q) state_d = ST_WLAST;
                    end
                end
            end
            ST_WLAST: state_d = TAIL_STATE;
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) state_d = (bus.rx_data == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE, ST_ERR: restart = start;
            default: state_d = ST_IDLE;
        endcase
        if (restart) begin
            state_d = ST_HDR0;
            lane_d  = '0;
            idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
        end
        rx_ready_d  = is_stream_state(state_d);
        busy_d      = is_stream_state(state_d) || (state_d == ST_WLAST);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERR);
        cpu_reset_d = (state_d == ST_DONE);
    end

    // State and output registers; reset aborts a load immediately without a write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            hdr_lo_q    <= '0;
            count_q     <= '0;
            lane_q      <= '0;
            idx_q       <= '0;
            rx_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hdr_lo_q    <= hdr_lo_d;
            count_q     <= count_d;
            lane_q      <= lane_d;
            idx_q       <= idx_d;
            rx_ready_q  <= rx_ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign bus.rx_ready       = rx_ready_q;
    assign bus.imem_test_we   = we_q;
    assign bus.imem_test_addr = addr_q;
    assign bus.imem_test_data = data_q;
    assign cpu_reset          = cpu_reset_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign error              = error_q;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: stream loads against a word-list reference model.
`timescale 1ns/1ps
module tb_imem_loader;
    import loader_pkg::*;

    localparam int MAX_WORDS = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          cpu_reset, busy, done, error;
    loader_state_e state_dbg;

    imem_loader_if bus ();

    imem_loader #(.MAX_WORDS(MAX_WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];     // {addr, data} of each expected write, in order
    logic [31:0] ld_words[$];  // payload words of the next load

    // scoreboard: every strobe must match the next expected write
    always @(negedge clk) begin
        if (bus.imem_test_we === 1'b1) begin
            logic [63:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write addr=%h data=%h (no write expected)",
                         bus.imem_test_addr, bus.imem_test_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.imem_test_addr, bus.imem_test_data} !== e) begin
                    n_fail++;
                    $display("FAIL write addr/data=%h/%h expected %h/%h",
                             bus.imem_test_addr, bus.imem_test_data, e[63:32], e[31:0]);
                end
            end
        end
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // driver: one-cycle start pulse, rx_ready must follow on the next cycle
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (bus.rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ready rx_ready=%b expected 1", bus.rx_ready);
        end
    endtask

    // driver: idle gap (optionally poking start), then present one byte until accepted
    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        bit acc;
        acc = 1'b0;
        for (int g = 0; g < gap; g++) begin
            start = poke && (g == 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = (bus.rx_ready === 1'b1);
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL byte_accept_timeout byte=%h rx_ready=%b expected 1", b, bus.rx_ready);
        end
    endtask

    // reference model + driver: builds the stream for n words of ld_words, predicts outcome
    task automatic run_load(input int n, input int gap_lo, input int gap_hi,
                            input bit poke, input bit bad_csum);
        logic [7:0]  stream[$];
        logic [31:0] w;
        bit          over, err;
        int          lat;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0]  x;
        x = 8'h00;
`endif
        over = (n > MAX_WORDS);
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        if (!over) begin
            for (int i = 0; i < n; i++) begin
                w = ld_words[i];
                exp_q.push_back({32'(i), w});
                for (int b = 0; b < 4; b++) begin
                    stream.push_back(w[8*b +: 8]);
`ifdef LOADER_CHECKSUM_EN
                    x = x ^ w[8*b +: 8];
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            stream.push_back(bad_csum ? (x ^ 8'h01) : x);
`endif
        end
        err = over || (bad_csum && !over);
`ifdef LOADER_CHECKSUM_EN
        lat = 1;
`else
        lat = (!over && n > 0) ? 2 : 1;
`endif
        do_start();
        foreach (stream[k]) send_byte(stream[k], $urandom_range(gap_hi, gap_lo), poke);
        if (lat == 2) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL early_done done=%b expected 0 during last strobe", done);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== !err) begin
            n_fail++; $display("FAIL done n=%0d done=%b expected %b", n, done, !err);
        end
        n_checks++;
        if (error !== err) begin
            n_fail++; $display("FAIL error n=%0d error=%b expected %b", n, error, err);
        end
        n_checks++;
        if (cpu_reset !== !err) begin
            n_fail++; $display("FAIL cpu_reset n=%0d cpu_reset=%b expected %b", n, cpu_reset, !err);
        end
        n_checks++;
        if ({bus.rx_ready, busy} !== 2'b00) begin
            n_fail++; $display("FAIL idle_flags rx_ready/busy=%b%b expected 00", bus.rx_ready, busy);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL missing_writes pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({bus.rx_ready, bus.imem_test_we, cpu_reset, busy, done, error} !== 6'b0) begin
            n_fail++;
            $display("FAIL %s_flags rdy/we/cpu_rst/busy/done/err=%b expected 000000", tag,
                     {bus.rx_ready, bus.imem_test_we, cpu_reset, busy, done, error});
        end
        n_checks++;
        if ({bus.imem_test_addr, bus.imem_test_data} !== 64'h0) begin
            n_fail++;
            $display("FAIL %s_bus addr=%h data=%h expected 0/0", tag,
                     bus.imem_test_addr, bus.imem_test_data);
        end
        n_checks++;
        if (state_dbg !== ST_IDLE) begin
            n_fail++; $display("FAIL %s_state state=%0d expected IDLE", tag, state_dbg);
        end
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_values("post_reset");
    endtask

    task automatic test_basic();
        ld_words = '{32'h00500013, 32'h00100093};
        run_load(2, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stalls();
        ld_words = '{32'h00500013, 32'h00100093};
        run_load(2, 3, 3, 1'b1, 1'b0);
    endtask

    task automatic test_zero_length();
        run_load(0, 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_oversize();
        run_load(257, 0, 0, 1'b0, 1'b0);
        // exactly MAX_WORDS is legal: loader must enter the payload phase
        do_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({bus.rx_ready, error, state_dbg} !== {1'b1, 1'b0, ST_DATA}) begin
            n_fail++;
            $display("FAIL max_words rx_ready=%b error=%b state=%0d expected 1/0/DATA",
                     bus.rx_ready, error, state_dbg);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_load();
        do_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h13, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        reset = 1'b0;
        #1;
        check_reset_values("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        ld_words = '{32'h00500013};
        run_load(1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(8, 1);
            ld_words.delete();
            for (int i = 0; i < n; i++) ld_words.push_back($urandom);
            run_load(n, 0, 2, 1'($urandom_range(1, 0)), 1'b0);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        ld_words = '{32'h04030201};
        run_load(1, 0, 0, 1'b0, 1'b0);
        run_load(1, 0, 1, 1'b0, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_zero_length();
        test_oversize();
        test_reset_mid_load();
        test_random();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
